// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with frame-synchronous capture, LZ suppression, PWM and ghost blanking
module seg7_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK = 2,
  parameter int BRIGHT_W = 4,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic [4*DIGITS-1:0]   Disp_Data,
  input  logic [DIGITS-1:0]     Dp_En,
  input  logic [DIGITS-1:0]     Digit_En,
  input  logic                  Lz_Supp,
  input  logic [BRIGHT_W-1:0]   Brightness,
  output logic [DIGITS-1:0]     Sel,
  output logic [7:0]            DisPlay,
  output logic                  Frame_Start
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [16*7-1:0] FONT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BRIGHT_W-1:0] pwm, sh_br;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0] sh_dp, sh_en, lz, oh;
  logic sh_lz, loaded, run, on, slot_end, frame_end;
  logic [3:0] nib;
  logic [7:0] seg;
  assign slot_end = cnt == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx == IW'(DIGITS - 1);
  // run stays high while every nibble from the top down to digit i is zero
  always_comb begin
    lz = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run = run && sh_data[4*i +: 4] == 4'h0;
      lz[i] = run && sh_lz;
    end
    nib = sh_data[{idx, 2'b00} +: 4];
    seg = {sh_dp[idx], lz[idx] ? 7'h00 : FONT[7*nib +: 7]};
    on = cnt >= CW'(BLANK) && sh_en[idx] && (&sh_br || pwm < sh_br);
    oh = on ? DIGITS'(1) << idx : '0;
  end
  // the first edge after reset only captures inputs; scanning starts on the next one
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
      sh_data <= '0;
      sh_dp <= '0;
      sh_en <= '0;
      sh_lz <= 1'b0;
      sh_br <= '0;
      loaded <= 1'b0;
      Sel <= SEL_OFF;
      DisPlay <= SEG_OFF;
      Frame_Start <= 1'b0;
    end else begin
      pwm <= pwm + 1'b1;
      loaded <= 1'b1;
      if (!loaded || frame_end) begin
        sh_data <= Disp_Data;
        sh_dp <= Dp_En;
        sh_en <= Digit_En;
        sh_lz <= Lz_Supp;
        sh_br <= Brightness;
      end
      if (loaded) begin
        cnt <= slot_end ? '0 : cnt + 1'b1;
        if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
        Sel <= SEL_ACTIVE_LOW != 0 ? ~oh : oh;
        DisPlay <= SEG_ACTIVE_LOW != 0 ? ~seg : seg;
        Frame_Start <= cnt == '0 && idx == '0;
      end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan, capture, LZ/dp, blanking/PWM and reset for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
  logic Clk = 1'b0, Reset_N = 1'b0;
  logic [31:0] Disp_Data;
  logic [7:0] Dp_En, Digit_En, Sel, DisPlay;
  logic Lz_Supp, Frame_Start;
  logic [1:0] Brightness;
  int n_vec = 0, n_err = 0, k = 0;
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_ctrl #(.DIGITS(8), .SCAN_DIV(16), .BLANK(2), .BRIGHT_W(2),
                   .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Disp_Data(Disp_Data), .Dp_En(Dp_En), .Digit_En(Digit_En),
    .Lz_Supp(Lz_Supp), .Brightness(Brightness), .Sel(Sel), .DisPlay(DisPlay), .Frame_Start(Frame_Start)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    k++;
  endtask

  task automatic sync_frame();
    do step(); while (k % 128 != 127);
    step();
  endtask

  task automatic test_reset();
    Disp_Data = 32'h12345678; Dp_En = 8'h00; Digit_En = 8'hFF; Lz_Supp = 1'b0; Brightness = 2'd3;
    Reset_N = 1'b0;
    repeat (2) @(negedge Clk);
    n_vec++; if (Sel !== 8'hFF) begin n_err++; $display("FAIL reset_sel got %h want ff", Sel); end
    n_vec++; if (DisPlay !== 8'hFF) begin n_err++; $display("FAIL reset_seg got %h want ff", DisPlay); end
    n_vec++; if (Frame_Start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b want 0", Frame_Start); end
    Reset_N = 1'b1;
    @(posedge Clk); @(negedge Clk);
    n_vec++; if (Frame_Start !== 1'b0) begin n_err++; $display("FAIL first_edge_fs got %b want 0", Frame_Start); end
    @(posedge Clk); @(negedge Clk);
    k = 0;
    n_vec++; if (Frame_Start !== 1'b1) begin n_err++; $display("FAIL second_edge_fs got %b want 1", Frame_Start); end
    n_vec++; if (DisPlay !== 8'h80) begin n_err++; $display("FAIL second_edge_seg got %h want 80", DisPlay); end
    n_vec++; if (Sel !== 8'hFF) begin n_err++; $display("FAIL second_edge_sel got %h want ff", Sel); end
  endtask

  task automatic test_basic_scan();
    logic [31:0] d = 32'h12345678;
    logic [7:0] es, ed;
    for (int c = 1; c <= 128; c++) begin
      step();
      es = (k % 16 < 2) ? 8'hFF : ~(8'b1 << ((k / 16) % 8));
      ed = ~{1'b0, FONT[d[4*((k/16)%8) +: 4]]};
      n_vec++; if (Sel !== es) begin n_err++; $display("FAIL basic_sel k=%0d got %h want %h", k, Sel, es); end
      n_vec++; if (DisPlay !== ed) begin n_err++; $display("FAIL basic_seg k=%0d got %h want %h", k, DisPlay, ed); end
      n_vec++; if (Frame_Start !== (k % 128 == 0)) begin
        n_err++; $display("FAIL basic_fs k=%0d got %b want %b", k, Frame_Start, k % 128 == 0); end
    end
  endtask

  task automatic test_tear_free();
    logic [31:0] o = 32'h12345678, n = 32'hABCDEF00;
    logic [7:0] ed;
    while (k < 128 + 3*16 + 5) step();
    Disp_Data = n;
    while (k < 384) begin
      ed = ~{1'b0, FONT[k < 256 ? o[4*((k/16)%8) +: 4] : n[4*((k/16)%8) +: 4]]};
      n_vec++; if (DisPlay !== ed) begin n_err++; $display("FAIL tear_seg k=%0d got %h want %h", k, DisPlay, ed); end
      step();
    end
  endtask

  task automatic test_lz_dp();
    logic [7:0] tab [8] = '{8'h3F, 8'hE6, 8'h6D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] es, ed;
    Lz_Supp = 1'b1; Disp_Data = 32'h00000540; Dp_En = 8'h02;
    sync_frame();
    for (int c = 0; c < 128; c++) begin
      es = (k % 16 < 2) ? 8'hFF : ~(8'b1 << ((k / 16) % 8));
      ed = ~tab[(k / 16) % 8];
      n_vec++; if (Sel !== es) begin n_err++; $display("FAIL lz_sel k=%0d got %h want %h", k, Sel, es); end
      n_vec++; if (DisPlay !== ed) begin n_err++; $display("FAIL lz_seg k=%0d got %h want %h", k, DisPlay, ed); end
      step();
    end
  endtask

  task automatic test_blank_pwm();
    int br [3] = '{3, 1, 0};
    logic [7:0] es;
    logic on;
    Lz_Supp = 1'b0; Dp_En = 8'h00; Digit_En = 8'hF0;
    for (int b = 0; b < 3; b++) begin
      Brightness = 2'(br[b]);
      sync_frame();
      for (int c = 0; c < 128; c++) begin
        on = k % 16 >= 2 && (k / 16) % 8 >= 4 && (br[b] == 3 || (k + 1) % 4 < br[b]);
        es = on ? ~(8'b1 << ((k / 16) % 8)) : 8'hFF;
        n_vec++; if (Sel !== es) begin
          n_err++; $display("FAIL pwm_sel br=%0d k=%0d got %h want %h", br[b], k, Sel, es); end
        step();
      end
    end
  endtask

  task automatic test_reset_mid();
    Digit_En = 8'hFF; Brightness = 2'd3; Disp_Data = 32'h12345678; Lz_Supp = 1'b0; Dp_En = 8'h00;
    sync_frame();
    while (k % 128 != 5*16 + 7) step();
    n_vec++; if (Sel !== 8'hDF) begin n_err++; $display("FAIL mid_pre_sel got %h want df", Sel); end
    n_vec++; if (DisPlay !== 8'hB0) begin n_err++; $display("FAIL mid_pre_seg got %h want b0", DisPlay); end
    Reset_N = 1'b0;
    #1;
    n_vec++; if (Sel !== 8'hFF) begin n_err++; $display("FAIL mid_rst_sel got %h want ff", Sel); end
    n_vec++; if (DisPlay !== 8'hFF) begin n_err++; $display("FAIL mid_rst_seg got %h want ff", DisPlay); end
    n_vec++; if (Frame_Start !== 1'b0) begin n_err++; $display("FAIL mid_rst_fs got %b want 0", Frame_Start); end
    @(negedge Clk);
    Reset_N = 1'b1;
    @(posedge Clk); @(negedge Clk);
    n_vec++; if (Frame_Start !== 1'b0) begin n_err++; $display("FAIL mid_first_fs got %b want 0", Frame_Start); end
    @(posedge Clk); @(negedge Clk);
    k = 0;
    n_vec++; if (Frame_Start !== 1'b1) begin n_err++; $display("FAIL mid_second_fs got %b want 1", Frame_Start); end
    n_vec++; if (DisPlay !== 8'h80) begin n_err++; $display("FAIL mid_second_seg got %h want 80", DisPlay); end
    step(); step();
    n_vec++; if (Sel !== 8'hFE) begin n_err++; $display("FAIL mid_restart_sel got %h want fe", Sel); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_lz_dp();
    test_blank_pwm();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
